// File: rtl/hit_scheduler.sv
// Frame-level hit / life-up arbiter for bomberman: collects overlaps per frame,
// issues lives requests at the frame tick and owns stun, invulnerability and blink.
module hit_scheduler #(
    parameter int FRAME_Y       = 480,
    parameter int STUN_FRAMES   = 30,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_FRAMES  = 4,
    parameter int MAX_LIVES     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       bm_hb_on,
    input  logic       enemy_on,
    input  logic       exp_on,
    input  logic       pickup_on,
    input  logic [2:0] lives_in,
    output logic       hit_pulse,
    output logic [1:0] hit_cause,
    output logic       life_up_pulse,
    output logic       pickup_consume,
    output logic       freeze,
    output logic       bm_blink,
    output logic       invuln,
    output logic       dead
);

    typedef enum logic [1:0] {ARMED, STUN, INVULN, DEAD} state_t;

    localparam logic [9:0] TICK_Y   = 10'(FRAME_Y);
    localparam logic [7:0] STUN_L   = 8'(STUN_FRAMES - 1);
    localparam logic [7:0] INVULN_L = 8'(INVULN_FRAMES - 1);
    localparam logic [7:0] BLINK_L  = 8'(BLINK_FRAMES - 1);
    localparam logic [2:0] MAX_L    = 3'(MAX_LIVES);

    state_t     state_q, state_d;
    logic       cond_q, cond_d;
    logic       exp_seen_q, exp_seen_d;
    logic       enemy_seen_q, enemy_seen_d;
    logic       pickup_seen_q, pickup_seen_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic       blink_q, blink_d;
    logic [1:0] cause_q, cause_d;
    logic       pend_q, pend_d;
    logic       pend_life_q, pend_life_d;

    logic tick, exp_now, enemy_now, pickup_now;
    logic lives_zero, hit, take_pickup, can_grow;

    // Rising edge of the tick position, so holding the pixel does not re-fire.
    assign cond_d     = (x == 10'd0) && (y == TICK_Y);
    assign tick       = cond_d & ~cond_q & ~reset;
    assign exp_now    = exp_seen_q    | (bm_hb_on & exp_on);
    assign enemy_now  = enemy_seen_q  | (bm_hb_on & enemy_on);
    assign pickup_now = pickup_seen_q | (bm_hb_on & pickup_on);
    assign lives_zero = (lives_in == 3'd0);
    assign can_grow   = (lives_in < MAX_L);
    assign hit        = tick && (state_q == ARMED) && !lives_zero
                        && (exp_now || enemy_now);
    assign take_pickup = tick && (state_q != DEAD) && !lives_zero
                         && pickup_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ARMED;
            cond_q        <= 1'b0;
            exp_seen_q    <= 1'b0;
            enemy_seen_q  <= 1'b0;
            pickup_seen_q <= 1'b0;
            cnt_q         <= 8'd0;
            bcnt_q        <= 8'd0;
            blink_q       <= 1'b0;
            cause_q       <= 2'b00;
            pend_q        <= 1'b0;
            pend_life_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cond_q        <= cond_d;
            exp_seen_q    <= exp_seen_d;
            enemy_seen_q  <= enemy_seen_d;
            pickup_seen_q <= pickup_seen_d;
            cnt_q         <= cnt_d;
            bcnt_q        <= bcnt_d;
            blink_q       <= blink_d;
            cause_q       <= cause_d;
            pend_q        <= pend_d;
            pend_life_q   <= pend_life_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bcnt_d        = bcnt_q;
        blink_d       = blink_q;
        cause_d       = cause_q;
        pend_d        = 1'b0;
        pend_life_d   = 1'b0;
        exp_seen_d    = tick ? 1'b0 : exp_now;
        enemy_seen_d  = tick ? 1'b0 : enemy_now;
        pickup_seen_d = tick ? 1'b0 : pickup_now;
        if (state_q != DEAD && lives_zero) begin
            state_d = DEAD;
            blink_d = 1'b0;
        end else if (tick) begin
            unique case (state_q)
                ARMED: begin
                    if (hit) begin
                        cause_d = exp_now ? 2'b10 : 2'b01;
                        cnt_d   = 8'd0;
                        state_d = (lives_in == 3'd1) ? DEAD : STUN;
                        // Pickup on a survivable hit is deferred one cycle.
                        if (take_pickup && lives_in != 3'd1) begin
                            pend_d      = 1'b1;
                            pend_life_d = can_grow;
                        end
                    end
                end
                STUN: begin
                    if (cnt_q == STUN_L) begin
                        state_d = INVULN;
                        cnt_d   = 8'd0;
                        bcnt_d  = 8'd0;
                        blink_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                INVULN: begin
                    if (cnt_q == INVULN_L) begin
                        state_d = ARMED;
                        cnt_d   = 8'd0;
                        blink_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        if (bcnt_q == BLINK_L) begin
                            bcnt_d  = 8'd0;
                            blink_d = ~blink_q;
                        end else begin
                            bcnt_d = bcnt_q + 8'd1;
                        end
                    end
                end
                DEAD: begin
                    state_d = DEAD;
                end
            endcase
        end
    end

    always_comb begin
        hit_pulse      = hit;
        hit_cause      = cause_q;
        pickup_consume = (take_pickup && !hit) || pend_q;
        life_up_pulse  = (take_pickup && !hit && can_grow)
                         || (pend_q && pend_life_q);
        freeze         = (state_q == STUN) || (state_q == DEAD);
        invuln         = (state_q == STUN) || (state_q == INVULN);
        bm_blink       = blink_q && (state_q == INVULN);
        dead           = (state_q == DEAD);
    end

endmodule

// File: tb/tb_hit_scheduler.sv
// Randomized frame-level stimulus for hit_scheduler with a scoreboard of
// expected request pulses and a per-cycle check of the status outputs.
module tb_hit_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic       bm_hb_on = 0, enemy_on = 0, exp_on = 0, pickup_on = 0;
    logic [2:0] lives_in = 3'd5;
    logic       hit_pulse, life_up_pulse, pickup_consume;
    logic       freeze, bm_blink, invuln, dead;
    logic [1:0] hit_cause;

    hit_scheduler dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .bm_hb_on(bm_hb_on), .enemy_on(enemy_on), .exp_on(exp_on),
        .pickup_on(pickup_on), .lives_in(lives_in),
        .hit_pulse(hit_pulse), .hit_cause(hit_cause),
        .life_up_pulse(life_up_pulse), .pickup_consume(pickup_consume),
        .freeze(freeze), .bm_blink(bm_blink), .invuln(invuln), .dead(dead)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic hit;
        logic up;
        logic con;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  mon_on = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: modes 0 ARMED, 1 STUN, 2 INVULN, 3 DEAD.
    int       m_mode, m_left, m_k, lives;
    logic [1:0] m_cause;
    bit       prev_cond, seen_e, seen_n, seen_p, pend, pend_life;
    int       cur_mode, cur_k;
    logic [1:0] cur_cause;

    function automatic logic [5:0] exp_levels(int mode, int k, logic [1:0] c);
        logic f, iv, b, d;
        f  = (mode == 1) || (mode == 3);
        iv = (mode == 1) || (mode == 2);
        b  = (mode == 2) && (((k / 4) % 2) == 0);
        d  = (mode == 3);
        return {f, iv, b, d, c};
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            logic [5:0] got, want;
            logic any;
            got  = {freeze, invuln, bm_blink, dead, hit_cause};
            want = exp_levels(cur_mode, cur_k, cur_cause);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL levels cyc=%0d got=%b want=%b", cyc, got, want);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse cyc=%0d got=none want_cyc=%0d",
                         cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            any = hit_pulse | life_up_pulse | pickup_consume;
            if (any || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_pulse cyc=%0d got=%b%b%b want=none",
                             cyc, hit_pulse, life_up_pulse, pickup_consume);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.hit !== hit_pulse ||
                        e.up !== life_up_pulse || e.con !== pickup_consume) begin
                        errors++;
                        $display("FAIL pulse cyc=%0d got=%b%b%b want=%b%b%b@%0d",
                                 cyc, hit_pulse, life_up_pulse, pickup_consume,
                                 e.hit, e.up, e.con, e.cyc);
                    end
                end
            end
        end
    end

    task automatic model_reset(int l);
        m_mode = 0; m_left = 0; m_k = 0; m_cause = 2'b00;
        prev_cond = 0; seen_e = 0; seen_n = 0; seen_p = 0;
        pend = 0; pend_life = 0; lives = l;
        cur_mode = 0; cur_k = 0; cur_cause = 2'b00;
        exp_q.delete();
    endtask

    task automatic do_reset(int l);
        @(posedge clk); #1;
        reset = 1; x = 0; y = 0;
        bm_hb_on = 0; enemy_on = 0; exp_on = 0; pickup_on = 0;
        model_reset(l);
        lives_in = 3'(l);
        mon_on = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic step(int xv, int yv, bit hb, bit en, bit ex, bit pk);
        bit cond, tick, e, n, p;
        ev_t ev;
        bit have;
        @(posedge clk);
        cur_mode = m_mode; cur_k = m_k; cur_cause = m_cause;
        #1;
        x = 10'(xv); y = 10'(yv);
        bm_hb_on = hb; enemy_on = en; exp_on = ex; pickup_on = pk;
        lives_in = 3'(lives);
        cond = (xv == 0) && (yv == 480);
        tick = cond && !prev_cond;
        prev_cond = cond;
        e = seen_e | (hb & ex);
        n = seen_n | (hb & en);
        p = seen_p | (hb & pk);
        ev = '{cyc, 1'b0, 1'b0, 1'b0};
        have = 0;
        if (pend) begin
            ev.con = 1; ev.up = pend_life; have = 1;
            if (pend_life) lives++;
            pend = 0;
        end
        if (m_mode != 3 && lives == 0) begin
            m_mode = 3;
        end else if (tick && m_mode != 3) begin
            if (m_mode == 0 && (e || n)) begin
                m_cause = e ? 2'b10 : 2'b01;
                ev.hit = 1; have = 1;
                if (lives == 1) m_mode = 3;
                else begin
                    m_mode = 1; m_left = 30;
                    if (p) begin pend = 1; pend_life = (lives < 5); end
                end
                lives--;
            end else begin
                if (p) begin
                    ev.con = 1; ev.up = (lives < 5); have = 1;
                    if (lives < 5) lives++;
                end
                if (m_mode == 1) begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 2; m_k = 0; end
                end else if (m_mode == 2) begin
                    m_k++;
                    if (m_k == 120) m_mode = 0;
                end
            end
        end
        if (tick) begin seen_e = 0; seen_n = 0; seen_p = 0; end
        else begin seen_e = e; seen_n = n; seen_p = p; end
        if (have) exp_q.push_back(ev);
    endtask

    task automatic rand_frame(int pe, int px, int pp);
        int len, hold, xv, yv;
        len  = $urandom_range(3, 12);
        hold = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) begin
            yv = $urandom_range(0, 480);
            xv = $urandom_range(0, 639);
            if (yv == 480 && xv == 0) xv = 1;
            step(xv, yv, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < pe, $urandom_range(0, 99) < px,
                 $urandom_range(0, 99) < pp);
        end
        for (int i = 0; i < hold; i++)
            step(0, 480, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < pe, $urandom_range(0, 99) < px,
                 $urandom_range(0, 99) < pp);
    endtask

    initial begin
        do_reset(5);
        // Enemy overlap held three cycles, then a long-held tick position.
        step(100, 200, 1, 1, 0, 0);
        step(101, 200, 1, 1, 0, 0);
        step(102, 200, 1, 1, 0, 0);
        step(5, 480, 1, 1, 1, 1);
        step(0, 480, 0, 0, 0, 0);
        step(0, 480, 0, 0, 0, 0);
        step(0, 480, 0, 0, 0, 0);
        repeat (160) rand_frame(0, 0, 0);
        // Explosion and enemy together in one frame, plus a pickup.
        step(50, 60, 1, 1, 1, 1);
        step(0, 480, 0, 0, 0, 0);
        for (int f = 0; f < 900; f++) begin
            if ($urandom_range(0, 299) == 0 ||
                (m_mode == 3 && $urandom_range(0, 3) == 0))
                do_reset($urandom_range(1, 5));
            if ($urandom_range(0, 3) == 0) rand_frame(0, 0, 0);
            else rand_frame(8, 4, 6);
        end
        // Lives reaching zero outside a hit must end the game.
        do_reset(3);
        step(10, 10, 0, 0, 0, 0);
        lives = 0;
        repeat (3) step(10, 10, 0, 0, 0, 0);
        step(0, 480, 1, 1, 0, 1);
        repeat (3) step(10, 10, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover got=%0d pending want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
